// File: rtl/fetch_ctrl.sv
// Fetch-side controller: sequences instruction-memory requests, hands fetched
// words to IF/ID, drives the PC register and holds delayed branch redirects.
module fetch_ctrl #(
  parameter logic [31:0] PC_STEP   = 32'd4,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        stall,
  input  logic        redir_valid,
  input  logic [31:0] redir_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_out,
  output logic        instr_valid,
  output logic        pc_en,
  output logic [31:0] next_pc,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] buf_q, buf_d;
  logic        pend_v_q, pend_v_d;
  logic [31:0] pend_t_q, pend_t_d;
  logic [31:0] count_q, count_d;

  logic        req_c;
  logic        handoff_c;
  logic [31:0] instr_c;

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    pend_v_d  = pend_v_q;
    pend_t_d  = pend_t_q;
    count_d   = count_q;
    req_c     = 1'b0;
    handoff_c = 1'b0;
    instr_c   = NOP_INSTR;

    case (state_q)
      ST_BOOT: state_d = ST_REQ;
      ST_REQ: begin
        req_c = 1'b1;
        if (imem_ready) begin
          if (!stall) begin
            handoff_c = 1'b1;
            instr_c   = imem_rdata;
          end else begin
            // Memory is never back-pressured; a stalled word parks here.
            buf_d   = imem_rdata;
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (!stall) begin
          handoff_c = 1'b1;
          instr_c   = buf_q;
          state_d   = ST_REQ;
        end
      end
      default: state_d = ST_BOOT;
    endcase

    if (handoff_c) begin
      count_d = count_q + 32'd1;
    end

    // The redirect waits for the delay slot's handoff; the handoff consumes it.
    if (handoff_c) begin
      pend_v_d = 1'b0;
    end else if (redir_valid) begin
      pend_v_d = 1'b1;
      pend_t_d = redir_target;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; the buffer is a
  // single register and is cleared with everything else on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_BOOT;
      buf_q    <= '0;
      pend_v_q <= 1'b0;
      pend_t_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      buf_q    <= buf_d;
      pend_v_q <= pend_v_d;
      pend_t_q <= pend_t_d;
      count_q  <= count_d;
    end
  end

  // Reset wins over whatever state the registers held when it arrived.
  always_comb begin
    imem_req    = req_c & ~reset;
    pc_en       = handoff_c & ~reset;
    instr_valid = handoff_c & ~reset;
    instr_out   = (handoff_c && !reset) ? instr_c : NOP_INSTR;
    fetch_count = reset ? '0 : count_q;

    if (!reset && redir_valid) begin
      next_pc = redir_target;
    end else if (!reset && pend_v_q) begin
      next_pc = pend_t_q;
    end else begin
      next_pc = pc + PC_STEP;
    end
  end

  assign imem_addr = pc;

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Fetch-side controller between the program counter register, a multi-cycle instruction memory, and the IF/ID pipeline register.
- Drives the PC register's enable and next-address inputs (pc_en, next_pc).
- Runs a req/ready handshake with instruction memory and hands each fetched word to IF/ID.
- Holds a branch/jump redirect from ID that arrives while the current fetch (delay slot) is still outstanding.

Parameters:
- PC_STEP, 4: sequential increment added to pc.
- NOP_INSTR, 32'h00000000: value driven on instr_out when instr_valid=0.

Ports:
- clk  input  1  clock
- reset  input  1  reset, synchronous, active-high
- pc  input  32  current PC from the PC register (reset value 32'h00003000)
- stall  input  1  hazard-unit stall; IF/ID holds, no handoff allowed
- redir_valid  input  1  ID stage requests a redirect (level, held while branch/jump sits in ID)
- redir_target  input  32  redirect address, valid with redir_valid
- imem_req  output  1  fetch request to instruction memory
- imem_addr  output  32  fetch address; equals pc
- imem_ready  input  1  memory returns data this cycle (sampled only when imem_req=1)
- imem_rdata  input  32  fetched word, valid with imem_ready
- instr_out  output  32  instruction to IF/ID
- instr_valid  output  1  instr_out is a real instruction; IF/ID loads a bubble when 0 and stall=0
- pc_en  output  1  enable to PC register
- next_pc  output  32  next PC value to PC register
- fetch_count  output  32  number of instructions handed off since reset

Behaviour:
- States:
  - BOOT: entered on reset; lasts 1 cycle; imem_req=0; goes to REQ.
  - REQ: imem_req=1, imem_addr=pc.
  - HOLD: word received but stalled; imem_req=0; word kept in a buffer.
- REQ transitions:
  - imem_ready=1 and stall=0: handoff; stay in REQ.
  - imem_ready=1 and stall=1: capture imem_rdata into the buffer; go to HOLD.
  - imem_ready=0: stay in REQ.
- HOLD transitions: stall=0: handoff from the buffer; go to REQ. Otherwise stay.
- Handoff cycle:
  - handoff = (REQ & imem_ready & !stall) | (HOLD & !stall).
  - pc_en = instr_valid = handoff.
  - instr_out = imem_rdata in REQ, buffer in HOLD, NOP_INSTR otherwise.
  - fetch_count increments by 1 on each handoff and wraps at 2^32.
- Back-to-back fetch: after a handoff in REQ, the next cycle requests the new pc, so there is zero idle cycles with single-cycle memory.
- Pending redirect register (pend_v, pend_t):
  - If redir_valid=1 and pc_en=0: pend_v<=1, pend_t<=redir_target. A newer request overwrites an older one.
  - If pc_en=1: pend_v<=0, regardless of redir_valid.
- next_pc priority (combinational):
  1. redir_valid=1: redir_target.
  2. Else pend_v=1: pend_t.
  3. Else pc+PC_STEP, modulo 2^32 (32'hFFFFFFFC+4 = 0).
- Delay-slot semantics: the redirect is applied at the handoff of the instruction currently in IF (the delay slot). It is never applied earlier, and the delay slot is never discarded.
- imem_addr is constant for the whole of an outstanding request. pc changes only on pc_en.
- Reset:
  - At any time, including mid-request, reset forces BOOT and clears pend_v, pend_t, the buffer and fetch_count.
  - Outstanding fetch is abandoned.
  - Reset-cycle outputs: imem_req=0, pc_en=0, instr_valid=0, instr_out=NOP_INSTR, fetch_count=0.
  - next_pc = pc+4 (32'h00003004 after PC reset).
- Interaction with stall:
  - stall=1 never blocks memory acceptance in REQ (the word is buffered).
  - stall=1 blocks only the handoff.
  - stall has no effect in BOOT.
- imem_ready while imem_req=0 is ignored.

Test Plan:
- Reset, single-cycle memory (imem_ready=1 always), rdata=addr: BOOT 1 cycle, then handoffs every cycle for pc=0x3000, 0x3004, 0x3008; fetch_count=3 after 3 handoffs.
- 3-cycle memory latency: imem_req held with imem_addr=0x3000 for 3 cycles; pc_en=1 only in the ready cycle; next_pc=0x3004.
- Ready with stall=1 for 2 cycles, rdata=0x2402000A: state HOLD, imem_req=0, pc_en=0; stall drop gives instr_out=0x2402000A, instr_valid=1, pc_en=1.
- Redirect during a 4-cycle fetch of delay slot 0x3004, with redir_valid pulsed 1 cycle, target 0x3100: pend latched; at handoff next_pc=0x3100; the following fetch is 0x3100; pend_v cleared.
- Pending target 0x3100 then a new redir_valid with target 0x3200 before handoff: next_pc=0x3200.
- Reset asserted mid-request at pc=0x3008: next cycle imem_req=0, fetch_count=0, pend cleared. pc=0xFFFFFFFC with no redirect gives next_pc=0.
